// File: rtl/sub_shift.sv
// -----------------------------------------------------------------------------
// sub_shift : AES SubBytes + ShiftRows (or InvSubBytes + InvShiftRows) stage.
//
// One 128-bit state is accepted in IDLE. It is then transformed one output
// column per cycle over four BUSY cycles, using four arithmetic S-boxes. The
// result is held in DONE until the downstream stage takes it.
//
// Parameters
//   INV        0 = encrypt (S-box, ShiftRows), 1 = decrypt (inverse S-box,
//              InvShiftRows)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a state block
//   in_ready   high only in IDLE
//   in_data    AES state, byte k = in_data[127-8k -: 8], k = row + 4*col
//   out_valid  high only in DONE
//   out_ready  downstream accepts the result
//   out_data   transformed state, same byte ordering as in_data
// -----------------------------------------------------------------------------
module sub_shift #(
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    logic [1:0]   col_r;
    logic [127:0] blk_r;

    logic [7:0]   blk_bytes_s [16];
    logic [7:0]   sbox_in_s   [4];
    logic [7:0]   sbox_out_s  [4];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Rotate a byte left by n (0..7).
    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward affine transform: b ^ rotl1..rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction

    // S-box or inverse S-box depending on INV.
    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        if (INV) begin
            return gf_inv(inv_affine(b));
        end else begin
            return affine(gf_inv(b));
        end
    endfunction

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);

    // Split the captured state into its 16 bytes, indexed k = row + 4*col.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            blk_bytes_s[k] = blk_r[127 - 8*k -: 8];
        end
    end

    // Pick the four source bytes for output column col_r: row r reads
    // column col+r (encrypt) or col-r (decrypt), modulo 4 via 2-bit wrap.
    always_comb begin
        logic [1:0] src_col_s;
        src_col_s = 2'd0;
        for (int r = 0; r < 4; r++) begin
            src_col_s     = INV ? (col_r - 2'(r)) : (col_r + 2'(r));
            sbox_in_s[r]  = blk_bytes_s[{src_col_s, 2'(r)}];
            sbox_out_s[r] = sbox_f(sbox_in_s[r]);
        end
    end

    // Control FSM, state capture and column-by-column result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            col_r    <= 2'd0;
            blk_r    <= 128'd0;
            out_data <= 128'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        blk_r   <= in_data;
                        col_r   <= 2'd0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    for (int c = 0; c < 4; c++) begin
                        if (col_r == 2'(c)) begin
                            for (int r = 0; r < 4; r++) begin
                                out_data[127 - 8*(r + 4*c) -: 8] <= sbox_out_s[r];
                            end
                        end
                    end
                    col_r <= col_r + 2'd1;
                    if (col_r == 2'd3) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    col_r   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_shift.sv
// -----------------------------------------------------------------------------
// tb_sub_shift : self-checking bench for sub_shift, one encrypt (INV=0) and
// one decrypt (INV=1) instance sharing clock and reset. Expected results come
// from a table-based S-box model built by brute-force field inversion and an
// index-arithmetic ShiftRows, plus published FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_sub_shift;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   in_valid_v;
    logic [1:0]   in_ready_v;
    logic [1:0]   out_valid_v;
    logic [1:0]   out_ready_v;
    logic [127:0] in_data_a  [2];
    logic [127:0] out_data_a [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    always #5 clk = ~clk;

    sub_shift #(.INV(1'b0)) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .in_data   (in_data_a[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .out_data  (out_data_a[0])
    );

    sub_shift #(.INV(1'b1)) u_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .in_data   (in_data_a[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .out_data  (out_data_a[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_affine(input logic [7:0] b);
        logic [7:0] o;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            o[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        end
        return o;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = ref_affine(inv);
        end
        for (int x = 0; x < 256; x++) begin
            isbox_t[sbox_t[x]] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_block(input int inv, input logic [127:0] din);
        logic [127:0] o;
        logic [7:0]   b;
        int           src;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = (inv != 0) ? ((c - r + 4) % 4) : ((c + r) % 4);
                b   = din[127 - 8*(r + 4*src) -: 8];
                o[127 - 8*(r + 4*c) -: 8] = (inv != 0) ? isbox_t[b] : sbox_t[b];
            end
        end
        return o;
    endfunction

    // ---------------- stimulus ----------------
    // Push one block through instance d; lat counts rising edges from the
    // accepting edge until out_valid is seen (20 = never arrived).
    task automatic run_block(input int d, input logic [127:0] din,
                             output logic [127:0] dout, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready_v[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_data_a[d]  = din;
        in_valid_v[d] = 1'b1;
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        lat = 1;
        while (!out_valid_v[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = out_data_a[d];
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid_v  = 2'b00;
        out_ready_v = 2'b00;
        in_data_a[0] = 128'd0;
        in_data_a[1] = 128'd0;
        #12;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0 || out_data_a[d] !== 128'd0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                         d, in_ready_v[d], out_valid_v[d], out_data_a[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        logic [127:0] dout;
        int lat;
        run_block(0, 128'd0, dout, lat);
        checks++;
        if (dout !== {16{8'h63}}) begin
            errors++;
            $display("FAIL zero_data: got %h want %h", dout, {16{8'h63}});
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_sequence();
        logic [127:0] dout;
        int lat;
        run_block(0, 128'h000102030405060708090a0b0c0d0e0f, dout, lat);
        checks++;
        if (dout[127:96] !== 32'h636b6776) begin
            errors++;
            $display("FAIL seq_col0: got %h want 636b6776", dout[127:96]);
        end
        checks++;
        if (dout !== ref_block(0, 128'h000102030405060708090a0b0c0d0e0f)) begin
            errors++;
            $display("FAIL seq_full: got %h want %h", dout,
                     ref_block(0, 128'h000102030405060708090a0b0c0d0e0f));
        end
    endtask

    task automatic test_fips();
        logic [127:0] dout;
        int lat;
        run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, dout, lat);
        checks++;
        if (dout !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
            errors++;
            $display("FAIL fips_enc: got %h want d4bf5d30e0b452aeb84111f11e2798e5", dout);
        end
        run_block(1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, dout, lat);
        checks++;
        if (dout !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
            errors++;
            $display("FAIL fips_dec: got %h want 193de3bea0f4e22b9ac68d2ae9f84808", dout);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL dec_latency: got %0d want 5", lat);
        end
    endtask

    task automatic test_random();
        logic [127:0] din, dout;
        int lat;
        for (int i = 0; i < 12; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_block(i % 2, din, dout, lat);
            checks++;
            if (dout !== ref_block(i % 2, din) || lat !== 5) begin
                errors++;
                $display("FAIL random[%0d] inv=%0d: got %h lat %0d want %h lat 5",
                         i, i % 2, dout, lat, ref_block(i % 2, din));
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] din, held;
        int n;
        din = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_data_a[0]  = din;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        n = 0;
        while (!out_valid_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = out_data_a[0];
        checks++;
        if (held !== ref_block(0, din)) begin
            errors++;
            $display("FAIL stall_data: got %h want %h", held, ref_block(0, din));
        end
        // A competing block is offered while the result is held.
        in_data_a[0]  = ~din;
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || out_data_a[0] !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b data=%h want 1 0 %h",
                         i, out_valid_v[0], in_ready_v[0], out_data_a[0], held);
            end
        end
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || out_data_a[0] !== held) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b data=%h want 1 0 %h",
                     in_ready_v[0], out_valid_v[0], out_data_a[0], held);
        end
    endtask

    task automatic test_reset_busy();
        logic [127:0] din, dout;
        int lat;
        din = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_data_a[0]  = din;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || out_data_a[0] !== 128'd0 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_reset: out_valid=%b data=%h in_ready=%b want 0 0 1",
                     out_valid_v[0], out_data_a[0], in_ready_v[0]);
        end
        #1;
        rst_n = 1'b1;
        din = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, din, dout, lat);
        checks++;
        if (dout !== ref_block(0, din) || lat !== 5) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d want %h lat 5", dout, lat, ref_block(0, din));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        int last_acc, seen, cyc;
        logic [127:0] din;
        @(negedge clk);
        out_ready_v[1] = 1'b1;
        in_valid_v[1]  = 1'b1;
        last_acc = -1;
        seen = 0;
        cyc  = 0;
        while (seen < 4 && cyc < 60) begin
            if (in_ready_v[1]) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                din = {$urandom, $urandom, $urandom, $urandom};
                in_data_a[1] = din;
                exp_q.push_back(ref_block(1, din));
            end
            if (out_valid_v[1]) begin
                checks++;
                if (exp_q.size() == 0 || out_data_a[1] !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h", seen, out_data_a[1]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                seen++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid_v[1]  = 1'b0;
        out_ready_v[1] = 1'b0;
        checks++;
        if (seen !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 4", seen);
        end
        // Drain the block accepted on the last loop iteration.
        repeat (8) @(negedge clk);
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        out_ready_v[1] = 1'b0;
    endtask

    initial begin
        build_tables();
        test_reset();
        test_zero();
        test_sequence();
        test_fips();
        test_random();
        test_stall();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
